// File: rtl/store_register_bank.sv
// store_register_bank: small bank of WIDTH-bit registers with read-modify-write
// store ops (LOAD/INC/CLR/ADD), one combinational read port and one registered,
// write-first read port. Carry and bad-address events are reported as pulses.

// One storage entry: holds its value unless selected for a write.
module store_register_bank_entry #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  // entry register, synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= wdata;
  end

endmodule

module store_register_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] q_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] q_b,
  output logic             ovf,
  output logic             err
);

  // Address space is padded to a power of two; pad slots read as zero and
  // are flagged out of range, so no magnitude compare against DEPTH is needed.
  localparam int NSLOT = 1 << AW;

  typedef enum logic [1:0] {OP_LOAD, OP_INC, OP_CLR, OP_ADD} op_e;

  typedef struct packed {
    logic             ok;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             carry;
  } wr_t;

  logic [NSLOT-1:0][WIDTH-1:0] slot;
  logic [NSLOT-1:0]            in_range;
  logic [WIDTH-1:0]            cur;
  logic [WIDTH:0]              res;
  wr_t                         wr;

  generate
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      if (i < DEPTH) begin : g_entry
        assign in_range[i] = 1'b1;
        store_register_bank_entry #(.WIDTH(WIDTH)) u_entry (
          .clk   (clk),
          .rst_n (rst_n),
          .we    (wr.ok && (wr.addr == AW'(i))),
          .wdata (wr.data),
          .q     (slot[i])
        );
      end else begin : g_pad
        assign in_range[i] = 1'b0;
        assign slot[i]     = '0;
      end
    end
  endgenerate

  assign cur = slot[waddr];
  assign q_a = slot[raddr_a];   // pre-edge value, no bypass

  // op datapath: one extra bit captures the carry of INC/ADD
  always_comb begin
    res = '0;
    case (op_e'(op))
      OP_LOAD: res = {1'b0, d};
      OP_INC:  res = {1'b0, cur} + (WIDTH+1)'(1);
      OP_CLR:  res = '0;
      OP_ADD:  res = {1'b0, cur} + {1'b0, d};
    endcase
  end

  // write request seen by the entries this cycle
  always_comb begin
    wr       = '0;
    wr.ok    = st && in_range[waddr];
    wr.addr  = waddr;
    wr.data  = res[WIDTH-1:0];
    wr.carry = res[WIDTH];   // LOAD/CLR never produce a carry
  end

  // registered read port (write-first) and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_b <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      q_b <= (wr.ok && (raddr_b == waddr)) ? wr.data : slot[raddr_b];
      ovf <= wr.ok && wr.carry;
      err <= st && !in_range[waddr];
    end
  end

endmodule

// File: tb/tb_store_register_bank.sv
// Bench for store_register_bank: two instances (DEPTH=4 and DEPTH=3) driven in
// lockstep and compared against an array-based reference model.
module tb_store_register_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [1:0]  waddr = 2'd0;
  logic [15:0] d = 16'h0;
  logic [1:0]  raddr_a = 2'd0;
  logic [1:0]  raddr_b = 2'd0;
  logic [15:0] qa4, qb4, qa3, qb3;
  logic        ovf4, err4, ovf3, err3;

  int total = 0;
  int bad   = 0;
  bit known = 0;

  // reference model: index 0 -> DEPTH 4, index 1 -> DEPTH 3
  int          dep [2] = '{4, 3};
  logic [15:0] m [2][4];
  logic [15:0] e_qb [2];
  logic        e_ovf [2];
  logic        e_err [2];

  always #5 clk = ~clk;

  store_register_bank #(.WIDTH(16), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .st(st), .op(op), .waddr(waddr), .d(d),
    .raddr_a(raddr_a), .q_a(qa4), .raddr_b(raddr_b), .q_b(qb4),
    .ovf(ovf4), .err(err4)
  );

  store_register_bank #(.WIDTH(16), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .st(st), .op(op), .waddr(waddr), .d(d),
    .raddr_a(raddr_a), .q_a(qa3), .raddr_b(raddr_b), .q_b(qb3),
    .ovf(ovf3), .err(err3)
  );

  function automatic logic [15:0] mrd(input int k, input int a);
    return (a < dep[k]) ? m[k][a] : 16'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // apply one clock edge to the model using plain arithmetic
  task automatic model_edge(input bit r, input bit s, input int o, input int wa,
                            input int dd, input int rb);
    int sum;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        for (int a = 0; a < 4; a++) m[k][a] = 16'h0;
        e_qb[k] = 16'h0; e_ovf[k] = 1'b0; e_err[k] = 1'b0;
      end else begin
        e_ovf[k] = 1'b0;
        e_err[k] = s && (wa >= dep[k]);
        if (s && wa < dep[k]) begin
          case (o)
            0: m[k][wa] = 16'(dd);
            1: begin sum = int'(m[k][wa]) + 1;  e_ovf[k] = (sum > 65535); m[k][wa] = 16'(sum % 65536); end
            2: m[k][wa] = 16'h0;
            default: begin sum = int'(m[k][wa]) + dd; e_ovf[k] = (sum > 65535); m[k][wa] = 16'(sum % 65536); end
          endcase
        end
        e_qb[k] = mrd(k, rb);
      end
    end
  endtask

  // one cycle: drive at negedge, check old q_a, clock, check all outputs
  task automatic cyc(input bit r, input bit s, input int o, input int wa,
                     input int dd, input int ra, input int rb);
    @(negedge clk);
    rst_n = r; st = s; op = 2'(o); waddr = 2'(wa); d = 16'(dd);
    raddr_a = 2'(ra); raddr_b = 2'(rb);
    #1;
    if (known) begin
      chk("qa_pre_d4", {16'h0, qa4}, {16'h0, mrd(0, ra)});
      chk("qa_pre_d3", {16'h0, qa3}, {16'h0, mrd(1, ra)});
    end
    @(posedge clk);
    model_edge(r, s, o, wa, dd, rb);
    known = 1;
    #1;
    chk("qa_d4",  {16'h0, qa4}, {16'h0, mrd(0, ra)});
    chk("qb_d4",  {16'h0, qb4}, {16'h0, e_qb[0]});
    chk("ovf_d4", {31'h0, ovf4}, {31'h0, e_ovf[0]});
    chk("err_d4", {31'h0, err4}, {31'h0, e_err[0]});
    chk("qa_d3",  {16'h0, qa3}, {16'h0, mrd(1, ra)});
    chk("qb_d3",  {16'h0, qb3}, {16'h0, e_qb[1]});
    chk("ovf_d3", {31'h0, ovf3}, {31'h0, e_ovf[1]});
    chk("err_d3", {31'h0, err3}, {31'h0, e_err[1]});
  endtask

  task automatic sweep();
    for (int a = 0; a < 4; a++) cyc(1, 0, 0, 0, 16'h5555, a, 3 - a);
  endtask

  initial begin
    // reset (inputs deliberately carry an INC that must be ignored)
    cyc(0, 1, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    sweep();

    // LOAD 0x1234 to entry 2, others stay 0
    cyc(1, 1, 0, 2, 16'h1234, 2, 0);
    sweep();

    // 0xFFFF + INC wraps with a single ovf pulse
    cyc(1, 1, 0, 1, 16'hFFFF, 1, 1);
    cyc(1, 1, 1, 1, 0, 1, 1);
    cyc(1, 0, 1, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);

    // ADD with and without carry
    cyc(1, 1, 0, 0, 16'h8000, 0, 0);
    cyc(1, 1, 3, 0, 16'h8001, 0, 0);
    cyc(1, 1, 3, 0, 16'h0001, 0, 0);

    // LOAD entry 3 while reading it on both ports (DEPTH 3 copy flags err)
    cyc(1, 1, 0, 3, 16'h7777, 3, 3);
    cyc(1, 1, 0, 3, 16'h00AA, 3, 3);
    cyc(1, 0, 0, 0, 0, 3, 3);

    // CLR, then back-to-back overflowing ADDs
    cyc(1, 1, 2, 2, 0, 2, 2);
    cyc(1, 1, 0, 1, 16'hFFFF, 1, 1);
    cyc(1, 1, 3, 1, 16'hFFFF, 1, 1);
    cyc(1, 1, 3, 1, 16'hFFFF, 1, 1);
    cyc(1, 0, 0, 1, 0, 1, 1);

    // st=0 holds for 10 cycles under random op/d
    for (int i = 0; i < 10; i++)
      cyc(1, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3));

    // reset in the same cycle as an overflowing INC
    cyc(1, 1, 0, 1, 16'hFFFF, 1, 1);
    cyc(0, 1, 1, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    sweep();

    // randomized traffic with occasional reset and biased operands
    for (int i = 0; i < 300; i++) begin
      int dd;
      dd = ($urandom_range(0, 3) == 0) ? 16'hFFFF - $urandom_range(0, 3) : int'($urandom % 65536);
      cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
          $urandom_range(0, 3), dd, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
